// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide (HI/LO) issue path:
//   - op-code constants MD_NONE .. MD_MTLO (shared with the HI/LO unit)
//   - default unit latencies for mult/multu and div/divu
//   - controller state type
//   - op classification helpers is_md / is_start / is_div
// ---------------------------------------------------------------------------
package md_pkg;

   localparam logic [3:0] MD_NONE  = 4'b0000;
   localparam logic [3:0] MD_MULT  = 4'b0010;
   localparam logic [3:0] MD_MULTU = 4'b0011;
   localparam logic [3:0] MD_DIV   = 4'b0100;
   localparam logic [3:0] MD_DIVU  = 4'b0101;
   localparam logic [3:0] MD_MFHI  = 4'b0110;
   localparam logic [3:0] MD_MFLO  = 4'b0111;
   localparam logic [3:0] MD_MTHI  = 4'b1000;
   localparam logic [3:0] MD_MTLO  = 4'b1001;

   localparam int MD_MUL_LAT_DEF = 5;
   localparam int MD_DIV_LAT_DEF = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } md_state_t;

   // Any of the eight HI/LO-class codes; all other codes behave as NONE.
   function automatic logic is_md(input logic [3:0] op);
      return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                        MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO};
   endfunction

   // Ops that start a multi-cycle multiply or divide in the unit.
   function automatic logic is_start(input logic [3:0] op);
      return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return op inside {MD_DIV, MD_DIVU};
   endfunction

endpackage

// File: rtl/md_issue.sv
// ---------------------------------------------------------------------------
// md_issue
// E-stage issue/stall controller for the HI/LO multiply/divide unit.
// Forwards MD-class ops and operands to the unit, stalls the pipeline while
// the unit is occupied, mirrors the unit latency with a local countdown,
// flags op/busy protocol mismatches and counts stalled cycles.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   md_valid   in   E-stage instruction valid
//   md_op      in   decoded MD op (md_pkg encoding)
//   rs_val     in   forwarded rs value
//   rt_val     in   forwarded rt value
//   md_busy    in   unit busy (registered busy OR start)
//   md_do      in   unit mfhi/mflo read data
//   hilo_op    out  op driven to the unit (NONE unless issued)
//   hilo_d1    out  operand 1 (rs) when issued, else 0
//   hilo_d2    out  operand 2 (rt) when issued, else 0
//   stall      out  freeze D/E stages this cycle
//   mf_data    out  mfhi/mflo result (pass-through of md_do)
//   err        out  sticky protocol-mismatch flag
//   stall_cnt  out  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module md_issue
   import md_pkg::*;
#(
   parameter int MUL_LAT = MD_MUL_LAT_DEF,
   parameter int DIV_LAT = MD_DIV_LAT_DEF,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             md_valid,
   input  logic [3:0]       md_op,
   input  logic [31:0]      rs_val,
   input  logic [31:0]      rt_val,
   input  logic             md_busy,
   input  logic [31:0]      md_do,
   output logic [3:0]       hilo_op,
   output logic [31:0]      hilo_d1,
   output logic [31:0]      hilo_d2,
   output logic             stall,
   output logic [31:0]      mf_data,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = ($clog2(LAT_MAX + 1) > 4) ? $clog2(LAT_MAX + 1) : 4;

   md_state_t        state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             err_reg, err_next;
   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

   logic md_sel;
   logic start_sel;
   logic busy_view;
   logic stall_int;
   logic issue;

   // Issue / stall decision. The unit's md_busy already includes its own
   // combinational start term, so that term is masked out when we are the
   // ones starting it this cycle; otherwise a start would stall itself.
   always_comb begin
      md_sel    = ~reset & md_valid & is_md(md_op);
      start_sel = md_sel & is_start(md_op);
      busy_view = md_busy & ~((state_reg == ST_IDLE) & start_sel);
      stall_int = md_sel & ((state_reg == ST_WAIT) | busy_view);
      issue     = md_sel & ~stall_int;
   end

   assign hilo_op   = issue ? md_op  : MD_NONE;
   assign hilo_d1   = issue ? rs_val : 32'd0;
   assign hilo_d2   = issue ? rt_val : 32'd0;
   assign stall     = stall_int;
   assign mf_data   = md_do;
   assign err       = err_reg;
   assign stall_cnt = stall_cnt_reg;

   // Next-state: FSM with its latency countdown, error flag, stall counter.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      err_next       = err_reg;
      stall_cnt_next = stall_cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (issue & start_sel) begin
               state_next = ST_WAIT;
               cnt_next   = is_div(md_op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
            end
         end
         ST_WAIT: begin
            if (cnt_reg == CW'(1)) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase

      // Unit went idle while we still expect it busy, or reports busy
      // when nothing was started.
      if (((state_reg == ST_WAIT) & ~md_busy) |
          ((state_reg == ST_IDLE) & (cnt_reg == '0) & md_busy &
           ~(start_sel & ~stall_int)))
         err_next = 1'b1;

      if (stall_int & (stall_cnt_reg != '1))
         stall_cnt_next = stall_cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         err_reg       <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         err_reg       <= err_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end

endmodule

// File: tb/tb_md_issue.sv
// ---------------------------------------------------------------------------
// tb_md_issue
// Scoreboard bench for md_issue. A behavioural HI/LO unit answers the DUT's
// op/busy interface; a reference model tracks "cycles the unit is still
// busy", HI/LO contents, err and the stall count from the op rules alone
// and pushes the expected per-cycle response into a queue. A monitor pops
// and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_md_issue;
   import md_pkg::*;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;
   localparam int CNT_W   = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             md_valid = 1'b0;
   logic [3:0]       md_op = 4'd0;
   logic [31:0]      rs_val = 32'd0;
   logic [31:0]      rt_val = 32'd0;
   logic             md_busy;
   logic [31:0]      md_do;
   logic [3:0]       hilo_op;
   logic [31:0]      hilo_d1;
   logic [31:0]      hilo_d2;
   logic             stall;
   logic [31:0]      mf_data;
   logic             err;
   logic [CNT_W-1:0] stall_cnt;

   always #5 clk = ~clk;

   md_issue #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
      .rs_val(rs_val), .rt_val(rt_val), .md_busy(md_busy), .md_do(md_do),
      .hilo_op(hilo_op), .hilo_d1(hilo_d1), .hilo_d2(hilo_d2),
      .stall(stall), .mf_data(mf_data), .err(err), .stall_cnt(stall_cnt)
   );

   // HI/LO arithmetic shared by the unit model and the reference model.
   // Division by zero is given a fixed result so both sides agree.
   function automatic logic [63:0] hilo_calc(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd2: return 64'(sa * sb);
         4'd3: return {32'd0, a} * {32'd0, b};
         4'd4: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         4'd5: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // ---------------- behavioural HI/LO unit ----------------
   int          unit_busy = 0;
   logic [31:0] u_hi = 32'd0;
   logic [31:0] u_lo = 32'd0;
   logic        drop_busy = 1'b0;
   logic        force_busy = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         unit_busy <= 0;
         u_hi      <= 32'd0;
         u_lo      <= 32'd0;
      end else begin
         if (unit_busy > 0) unit_busy <= unit_busy - 1;
         case (hilo_op)
            4'd2, 4'd3, 4'd4, 4'd5: begin
               {u_hi, u_lo} <= hilo_calc(hilo_op, hilo_d1, hilo_d2);
               unit_busy    <= (hilo_op == 4'd4 || hilo_op == 4'd5) ? DIV_LAT : MUL_LAT;
            end
            4'd8:    u_hi <= hilo_d1;
            4'd9:    u_lo <= hilo_d1;
            default: ;
         endcase
      end
   end

   assign md_busy = force_busy |
                    (~drop_busy & ~reset &
                     ((unit_busy != 0) | (md_valid & (md_op >= 4'd2) & (md_op <= 4'd5))));
   assign md_do   = (md_op == 4'd6) ? u_hi : u_lo;

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      int          cyc;
      logic        rst;
      logic [3:0]  op;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        stl;
      logic        mf_chk;
      logic [31:0] mf;
      logic        err;
      logic [31:0] scnt;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          m_busy = 0;       // cycles the unit remains busy
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic        m_err = 1'b0;
   logic [31:0] m_scnt = 32'd0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic step(input logic rst, input logic v, input logic [3:0] op,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic drop, input logic fb);
      exp_t e;
      logic md, st, stl, iss;
      logic [63:0] r;
      @(posedge clk);
      #1;
      reset = rst; md_valid = v; md_op = op; rs_val = rs; rt_val = rt;
      drop_busy = drop; force_busy = fb;
      cyc++;
      md  = !rst && v && op >= 4'd2 && op <= 4'd9;
      st  = md && op <= 4'd5;
      stl = md && m_busy > 0;
      iss = md && !stl;
      e.cyc    = cyc;
      e.rst    = rst;
      e.op     = iss ? op : 4'd0;
      e.d1     = iss ? rs : 32'd0;
      e.d2     = iss ? rt : 32'd0;
      e.stl    = stl;
      e.mf_chk = iss && (op == 4'd6 || op == 4'd7);
      e.mf     = (op == 4'd6) ? m_hi : m_lo;
      e.err    = m_err;
      e.scnt   = m_scnt;
      sb_q.push_back(e);
      // advance the model across the coming edge
      if (rst) begin
         m_busy = 0; m_err = 1'b0; m_scnt = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
      end else begin
         if ((m_busy > 0 && drop) || (m_busy == 0 && fb && !(iss && st))) m_err = 1'b1;
         if (stl && m_scnt != 32'hFFFF_FFFF) m_scnt++;
         if (m_busy > 0) m_busy--;
         if (iss && st) begin
            r = hilo_calc(op, rs, rt);
            m_hi = r[63:32];
            m_lo = r[31:0];
            m_busy = (op >= 4'd4) ? DIV_LAT : MUL_LAT;
         end else if (iss && op == 4'd8) m_hi = rs;
         else if (iss && op == 4'd9) m_lo = rs;
      end
   endtask

   task automatic op_cyc(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      step(1'b0, 1'b1, op, rs, rt, 1'b0, 1'b0);
   endtask

   task automatic nop_cyc();
      step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic rst_cyc();
      step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s cyc %0d: got %h expected %h", name, mon_e.cyc, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         $display("cyc %0d rst=%0b op=%h d1=%h d2=%h stall=%0b mf=%h err=%0b cnt=%0d",
                  mon_e.cyc, mon_e.rst, hilo_op, hilo_d1, hilo_d2, stall, mf_data, err, stall_cnt);
         chk("hilo_op", 32'(hilo_op), 32'(mon_e.op));
         chk("hilo_d1", hilo_d1, mon_e.d1);
         chk("hilo_d2", hilo_d2, mon_e.d2);
         chk("stall", 32'(stall), 32'(mon_e.stl));
         if (mon_e.mf_chk) chk("mf_data", mf_data, mon_e.mf);
         if (!mon_e.rst) begin
            chk("err", 32'(err), 32'(mon_e.err));
            chk("stall_cnt", stall_cnt, mon_e.scnt);
         end
      end
   end

   initial begin
      rst_cyc();
      rst_cyc();

      // MULT 3 * -4, MFLO right behind it: 5 stall cycles, then 0xFFFFFFF4
      op_cyc(MD_MULT, 32'd3, 32'hFFFF_FFFC);
      for (int i = 0; i < 6; i++) op_cyc(MD_MFLO, 32'd0, 32'd0);

      // DIVU 7 / 2, MFHI stalls 10 cycles then reads 1; MFLO reads 3
      op_cyc(MD_DIVU, 32'd7, 32'd2);
      for (int i = 0; i < 11; i++) op_cyc(MD_MFHI, 32'd0, 32'd0);
      op_cyc(MD_MFLO, 32'd0, 32'd0);

      // MTHI then MFHI with no stall
      op_cyc(MD_MTHI, 32'h1234, 32'd0);
      op_cyc(MD_MFHI, 32'd0, 32'd0);
      nop_cyc();

      // MULT followed by non-MD instructions during WAIT: never stalled
      op_cyc(MD_MULT, 32'd9, 32'd9);
      for (int i = 0; i < 6; i++) op_cyc((i % 2 == 0) ? 4'd0 : 4'hF, 32'd1, 32'd2);

      // DIV with busy dropped at T+3: err sticks until reset
      op_cyc(MD_DIV, 32'd100, 32'd7);
      nop_cyc();
      nop_cyc();
      step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) nop_cyc();
      rst_cyc();
      nop_cyc();

      // Reset in the middle of WAIT, then a MULT issues at once
      op_cyc(MD_MULT, 32'd6, 32'd7);
      nop_cyc();
      rst_cyc();
      op_cyc(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      for (int i = 0; i < 6; i++) op_cyc(MD_MFHI, 32'd0, 32'd0);

      // Unit claims busy with no start in IDLE
      step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      nop_cyc();
      nop_cyc();
      rst_cyc();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rs, rt;
         rs = $urandom();
         rt = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom_range(0, 3) == 0 ? $urandom_range(1, 9) : $urandom();
         if ($urandom_range(0, 79) == 0)
            rst_cyc();
         else
            step(1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rs, rt, 1'b0, 1'b0);
      end
      nop_cyc();

      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/md_issue.md
# md_issue

Issue and stall controller for the multiply/divide (HI/LO) unit in the E stage of the pipelined MIPS core. It is the initiator side of the HI/LO unit's op/busy interface. It forwards MD-class instructions (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) with their operands and holds the pipeline while the unit is occupied. It also mirrors the unit's latency with its own countdown, flags protocol mismatches, and counts stall cycles.

## Interface
- MUL_LAT, default 5: cycles the unit stays busy after a mult/multu is accepted.
- DIV_LAT, default 10: cycles the unit stays busy after a div/divu is accepted.
- CNT_W, default 32: width of the stall-cycle counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- md_valid  in  1  E-stage instruction is valid.
- md_op  in  4  decoded MD op (shared encoding).
- rs_val  in  32  forwarded rs value.
- rt_val  in  32  forwarded rt value.
- md_busy  in  1  unit Busy: registered busy OR start.
- md_do  in  32  unit mfhi/mflo read data.
- hilo_op  out  4  op driven to the unit.
- hilo_d1  out  32  operand 1 (rs).
- hilo_d2  out  32  operand 2 (rt).
- stall  out  1  freeze D/E stages this cycle.
- mf_data  out  32  mfhi/mflo result to the E-stage result mux.
- err  out  1  sticky protocol-mismatch flag.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- Op encoding:
  - NONE = 0000.
  - MULT = 0010, MULTU = 0011, DIV = 0100, DIVU = 0101.
  - MFHI = 0110, MFLO = 0111, MTHI = 1000, MTLO = 1001.
  - Every other code is treated as NONE.
- is_md = md_valid & (md_op is one of the eight MD codes). is_start = is_md & op ∈ {MULT, MULTU, DIV, DIVU}.
- FSM states:
  - IDLE.
  - WAIT, which has a countdown `cnt`, 4 bits wide or wider.
- stall = is_md & (state == WAIT | md_busy_reg_view). md_busy_reg_view = md_busy & ~(state == IDLE & is_start), which excludes the unit's own combinational start term.
- Issue:
  - When is_md and ~stall: hilo_op = md_op, hilo_d1 = rs_val, hilo_d2 = rt_val.
  - Otherwise: hilo_op = NONE, and d1/d2 = 0.
  - All three are combinational.
- mf_data = md_do, passed through combinationally. It is meaningful only when MFHI/MFLO is issued unstalled.
- Transitions:
  - IDLE → WAIT on an issued start. cnt loads MUL_LAT for mult/multu and DIV_LAT for div/divu.
  - WAIT: cnt decrements each edge. When the edge sees cnt == 1, the next state is IDLE and cnt becomes 0.
  - mthi/mtlo/mf* never leave IDLE.
- err is set and held until reset when either of these holds:
  - state == WAIT & ~md_busy (unit finished early or dropped the op).
  - state == IDLE & cnt == 0 & md_busy & ~(is_start & ~stall) (unit busy without a start).
- stall_cnt increments on every cycle with stall = 1 and saturates at all-ones.
- Reset, including mid-WAIT: state = IDLE, cnt = 0, err = 0, stall_cnt = 0. The unit shares the same reset, so no drain is needed.

## Timing
- Reset values:
  - hilo_op = NONE, hilo_d1 = 0, hilo_d2 = 0.
  - stall = 0 (is_md is ignored during reset), err = 0, stall_cnt = 0.
  - mf_data follows md_do.
- Start issued in cycle T:
  - WAIT is active in cycles T+1 through T+MUL_LAT (or T+DIV_LAT).
  - IDLE again at T+LAT+1.
  - An MD instruction is accepted in cycle T+LAT+1 and reads the new HI/LO.
- Back-to-back: an MD op in cycle T+1 after a start in T is stalled for exactly LAT cycles.
- Non-MD instructions are never stalled, even while in WAIT.
- mthi/mtlo issued in IDLE: the unit writes on that edge, so an mf* in the next cycle sees the new value with no stall.
- When the stall and the stall_cnt increment happen in the same cycle, the counter updates on that edge.

## Structure
- Shared package md_pkg holds:
  - The op-code constants MD_NONE through MD_MTLO.
  - The default MUL_LAT and DIV_LAT.
  - The is_start/is_md helper functions.
- The design is flat; no sub-module is warranted. The countdown and the FSM live in one always block, and the issue/stall logic is combinational.

## Test plan
- Reset, then MULT (rs = 3, rt = −4), then MFLO the next cycle → MFLO stalls 5 cycles, stall_cnt = 5, and after release mf_data = 0xFFFFFFF4.
- DIVU (rs = 7, rt = 2), then MFHI → stall for 10 cycles, then mf_data = 1. A second MFLO with no stall returns 3.
- MTHI 0x1234, then MFHI in the following cycle → no stall, mf_data = 0x1234, state stays IDLE.
- MULT, with ADD-class instructions during WAIT → stall = 0 throughout, and hilo_op = NONE after the issue cycle.
- Bench model drops md_busy at cycle T+3 of a DIV → err = 1 from the next edge and held; reset clears it.
- Reset asserted mid-WAIT (cnt = 4) → next cycle state IDLE, stall = 0, and a new MULT is issued immediately.
